// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine among NUM_REQ
// register-access requesters, with a per-transaction timeout watchdog.
module i2c_txn_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_dev,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]   req_rnw,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 eng_start,
    output logic [6:0]           eng_dev,
    output logic [7:0]           eng_reg,
    output logic [7:0]           eng_wdata,
    output logic                 eng_rnw,
    input  logic                 eng_done,
    input  logic                 eng_nack,
    input  logic [7:0]           eng_rdata,
    output logic                 eng_abort,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [CW-1:0]  cnt;
    logic           expired;
    logic           win_valid;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;

    assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Abort must see eng_done in the same cycle so a coincident completion wins.
    assign eng_abort = (state == WAIT) && expired && !eng_done;

    // Round-robin scan from last_grant+1; descending loop leaves the nearest hit.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((32'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_OK;
            eng_start  <= 1'b0;
            eng_dev    <= '0;
            eng_reg    <= '0;
            eng_wdata  <= '0;
            eng_rnw    <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        grant_id  <= win_idx;
                        eng_dev   <= req_dev[7*win_idx +: 7];
                        eng_reg   <= req_reg[8*win_idx +: 8];
                        eng_wdata <= req_wdata[8*win_idx +: 8];
                        eng_rnw   <= req_rnw[win_idx];
                        eng_start <= 1'b1;
                        req_ready <= ONE_HOT0 << win_idx;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (eng_done) begin
                        // Data from a NACKed or write transfer is meaningless; return zero.
                        rsp_rdata <= (eng_rnw && !eng_nack) ? eng_rdata : 8'h00;
                        rsp_err   <= eng_nack ? ERR_NACK : ERR_OK;
                        rsp_valid <= ONE_HOT0 << grant_id;
                        state     <= RESP;
                    end else if (expired) begin
                        rsp_rdata <= 8'h00;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_valid <= ONE_HOT0 << grant_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed vector table, hand-written
// reset/fairness sequences and a randomized run against a round-robin model.
module tb_i2c_txn_arbiter;

    localparam int NR = 3;
    localparam int TO = 16;

    logic          clk;
    logic          reset_n;
    logic [NR-1:0] req_valid;
    logic [7*NR-1:0] req_dev;
    logic [8*NR-1:0] req_reg;
    logic [8*NR-1:0] req_wdata;
    logic [NR-1:0] req_rnw;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] rsp_valid;
    logic [7:0]    rsp_rdata;
    logic [1:0]    rsp_err;
    logic          eng_start;
    logic [6:0]    eng_dev;
    logic [7:0]    eng_reg;
    logic [7:0]    eng_wdata;
    logic          eng_rnw;
    logic          eng_done;
    logic          eng_nack;
    logic [7:0]    eng_rdata;
    logic          eng_abort;
    logic [1:0]    grant_id;
    logic          busy;

    i2c_txn_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_dev(req_dev), .req_reg(req_reg),
        .req_wdata(req_wdata), .req_rnw(req_rnw), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_dev(eng_dev), .eng_reg(eng_reg),
        .eng_wdata(eng_wdata), .eng_rnw(eng_rnw), .eng_done(eng_done),
        .eng_nack(eng_nack), .eng_rdata(eng_rdata), .eng_abort(eng_abort),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] p_dev[NR];
    logic [7:0] p_reg[NR];
    logic [7:0] p_wdata[NR];
    logic       p_rnw[NR];
    int         last_g;

    typedef struct {
        int         idx;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       rnw;
        int         lat;     // 0 = engine never completes, else done in WAIT cycle lat
        logic       nack;
        logic [7:0] rd;
        logic [1:0] err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [6:0] d, input logic [7:0] r,
                        input logic [7:0] w, input logic rnw);
        p_dev[i] = d; p_reg[i] = r; p_wdata[i] = w; p_rnw[i] = rnw;
        req_dev[7*i +: 7]   = d;
        req_reg[8*i +: 8]   = r;
        req_wdata[8*i +: 8] = w;
        req_rnw[i]          = rnw;
        req_valid[i]        = 1'b1;
    endtask

    // Runs one transaction from an IDLE cycle with the winner's request already driven.
    task automatic txn(input int w, input int lat, input logic nack, input logic [7:0] rd,
                       input logic [1:0] err, input logic [7:0] exp_rd, input bit keep);
        logic [NR-1:0] oh;
        oh = NR'(1) << w;
        chk("idle_busy", 32'(busy), 0);
        tick;
        chk("req_ready", 32'(req_ready), 32'(oh));
        chk("eng_start", 32'(eng_start), 1);
        chk("grant_id", 32'(grant_id), w);
        chk("eng_dev", 32'(eng_dev), 32'(p_dev[w]));
        chk("eng_reg", 32'(eng_reg), 32'(p_reg[w]));
        chk("eng_wdata", 32'(eng_wdata), 32'(p_wdata[w]));
        chk("eng_rnw", 32'(eng_rnw), 32'(p_rnw[w]));
        if (!keep) req_valid[w] = 1'b0;
        tick;
        for (int c = 0; c < TO; c++) begin
            chk("wait_quiet", 32'({eng_start, req_ready, rsp_valid}), 0);
            if (lat == c + 1) begin
                eng_done = 1'b1; eng_nack = nack; eng_rdata = rd;
                #1;
                chk("abort_on_done", 32'(eng_abort), 0);
                tick;
                eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'($urandom);
                break;
            end
            #1;
            chk("abort", 32'(eng_abort), 32'(lat == 0 && c == TO - 1));
            tick;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("resp_busy", 32'(busy), 1);
        chk("eng_dev_stable", 32'(eng_dev), 32'(p_dev[w]));
        tick;
        chk("rsp_valid_pulse", 32'(rsp_valid), 0);
        chk("rdata_held", 32'(rsp_rdata), 32'(exp_rd));
        chk("err_held", 32'(rsp_err), 32'(err));
        last_g = w;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] pend, input int last);
        for (int k = 1; k <= NR; k++)
            if (pend[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    initial begin
        tbl[0] = '{1, 7'h3C, 8'h12, 8'hA5, 1'b0, 12, 1'b0, 8'h77, 2'b00, 8'h00};
        tbl[1] = '{2, 7'h10, 8'h00, 8'h00, 1'b1, 5,  1'b0, 8'h5A, 2'b00, 8'h5A};
        tbl[2] = '{0, 7'h20, 8'h01, 8'h33, 1'b0, 3,  1'b1, 8'h00, 2'b01, 8'h00};
        tbl[3] = '{1, 7'h48, 8'h7F, 8'h00, 1'b1, 2,  1'b1, 8'hC3, 2'b01, 8'h00};
        tbl[4] = '{2, 7'h0C, 8'h40, 8'h00, 1'b1, 0,  1'b0, 8'h99, 2'b10, 8'h00};
        tbl[5] = '{0, 7'h51, 8'hE0, 8'h00, 1'b1, TO, 1'b0, 8'h81, 2'b00, 8'h81};
        tbl[6] = '{1, 7'h3C, 8'h13, 8'h5A, 1'b0, 1,  1'b0, 8'hFF, 2'b00, 8'h00};

        reset_n = 1'b0; req_valid = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
        req_rnw = '0; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = '0;
        last_g = NR - 1;
        for (int i = 0; i < NR; i++) post(i, 7'(8'h30 + i), 8'(i), 8'(8'hB0 + i), 1'b1);
        tick; tick;
        chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start,
                                  eng_abort, grant_id}), 0);
        chk("reset_eng", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 0);
        chk("reset_busy", 32'(busy), 0);
        reset_n = 1'b1;

        // Fairness: all three held continuously from reset.
        for (int n = 0; n < 6; n++)
            txn(n % NR, 2 + n, 1'b0, 8'(8'h60 + n), 2'b00, 8'(8'h60 + n), 1'b1);
        req_valid = '0;
        tick;

        // eng_done outside WAIT must be ignored.
        eng_done = 1'b1; eng_nack = 1'b1;
        tick;
        eng_done = 1'b0; eng_nack = 1'b0;
        tick;
        chk("stray_done", 32'({busy, rsp_valid, eng_start}), 0);

        for (int v = 0; v < 7; v++) begin
            post(tbl[v].idx, tbl[v].dev, tbl[v].rg, tbl[v].wd, tbl[v].rnw);
            txn(tbl[v].idx, tbl[v].lat, tbl[v].nack, tbl[v].rd, tbl[v].err, tbl[v].exp_rd, 1'b0);
        end

        // Randomized traffic against the round-robin model.
        for (int n = 0; n < 60; n++) begin
            int w, lat, r;
            logic nack;
            logic [7:0] rd;
            logic [1:0] err;
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    post(i, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            if (req_valid == '0) begin
                w = $urandom_range(0, NR - 1);
                post(w, 7'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            end
            w = rr_pick(req_valid, last_g);
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, TO - 1);
            nack = ($urandom_range(0, 3) == 0);
            rd = 8'($urandom);
            err = (lat == 0) ? 2'b10 : (nack ? 2'b01 : 2'b00);
            txn(w, lat, nack, rd, err,
                (lat == 0 || nack || !p_rnw[w]) ? 8'h00 : rd, 1'b0);
        end
        req_valid = '0;
        tick;

        // Reset mid-WAIT, after a read that leaves non-zero data behind.
        post(2, 7'h11, 8'h22, 8'h00, 1'b1);
        txn(2, 4, 1'b0, 8'hE7, 2'b00, 8'hE7, 1'b0);
        post(1, 7'h2A, 8'h05, 8'h00, 1'b1);
        tick;
        req_valid[1] = 1'b0;
        tick; tick; tick;
        reset_n = 1'b0;
        tick;
        chk("midreset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start,
                                     eng_abort, grant_id}), 0);
        chk("midreset_eng", 32'({eng_dev, eng_reg, eng_wdata, eng_rnw}), 0);
        chk("midreset_busy", 32'(busy), 0);
        reset_n = 1'b1;
        last_g = NR - 1;
        post(1, 7'h2A, 8'h05, 8'h00, 1'b1);
        post(0, 7'h3C, 8'h06, 8'h44, 1'b0);
        txn(0, 0, 1'b0, 8'h00, 2'b10, 8'h00, 1'b0);
        txn(1, 6, 1'b0, 8'h3D, 2'b00, 8'h3D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
